// File: rtl/moore_run_detector.sv
// rtl/moore_run_detector.sv - Moore run-length detector with retrigger mode, rise pulse and event counter
module moore_run_detector #(
  parameter int RUN_LEN   = 2,
  parameter int CNT_W     = 4,
  parameter int EVT_W     = 8,
  parameter int RETRIGGER = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             w,
  input  logic             polarity,
  output logic             z,
  output logic             z_rise,
  output logic [CNT_W-1:0] run_count,
  output logic [EVT_W-1:0] event_count
);

  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(RUN_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [EVT_W-1:0] EVT_MAX = '1;
  // A single-sample run in retrigger mode completes a fresh run on every match.
  localparam bit REFIRE = (RETRIGGER != 0) && (RUN_LEN == 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             at_max;
  logic             hit;

  always_comb begin
    at_max  = (cnt == RUN_MAX);
    cnt_nxt = cnt;
    if (w != polarity) begin
      cnt_nxt = '0;
    end else if (at_max) begin
      cnt_nxt = (RETRIGGER != 0) ? CNT_ONE : RUN_MAX;
    end else begin
      cnt_nxt = cnt + CNT_ONE;
    end
    hit = en && (cnt_nxt == RUN_MAX) && (!at_max || REFIRE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt         <= '0;
      z_rise      <= 1'b0;
      event_count <= '0;
    end else if (en) begin
      cnt    <= cnt_nxt;
      z_rise <= hit;
      if (hit && (event_count != EVT_MAX)) begin
        event_count <= event_count + 1'b1;
      end
    end else begin
      z_rise <= 1'b0;
    end
  end

  // Moore output: decoded from the state register only.
  assign z         = (cnt == RUN_MAX);
  assign run_count = cnt;

endmodule

// File: tb/tb_moore_run_detector.sv
// tb/tb_moore_run_detector.sv - directed scoreboard bench over several detector configurations
module tb_moore_run_detector;

  localparam int NDUT = 6;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic en = 1'b0;
  logic w = 1'b0;
  logic polarity = 1'b1;

  logic       z_o   [NDUT];
  logic       r_o   [NDUT];
  logic [3:0] c_o   [NDUT];
  logic [7:0] e_o   [NDUT];
  logic [1:0] e_sat;

  always #5 clock = ~clock;

  // 0: legacy (2,sticky) 1: (3,retrigger) 2: (3,sticky) 3: (1,sticky,EVT_W=2) 4: (4,sticky) 5: (1,retrigger)
  moore_run_detector #(.RUN_LEN(2), .CNT_W(4), .EVT_W(8), .RETRIGGER(0)) d0 (
    .clock(clock), .reset(reset), .en(en), .w(w), .polarity(polarity),
    .z(z_o[0]), .z_rise(r_o[0]), .run_count(c_o[0]), .event_count(e_o[0]));
  moore_run_detector #(.RUN_LEN(3), .CNT_W(4), .EVT_W(8), .RETRIGGER(1)) d1 (
    .clock(clock), .reset(reset), .en(en), .w(w), .polarity(polarity),
    .z(z_o[1]), .z_rise(r_o[1]), .run_count(c_o[1]), .event_count(e_o[1]));
  moore_run_detector #(.RUN_LEN(3), .CNT_W(4), .EVT_W(8), .RETRIGGER(0)) d2 (
    .clock(clock), .reset(reset), .en(en), .w(w), .polarity(polarity),
    .z(z_o[2]), .z_rise(r_o[2]), .run_count(c_o[2]), .event_count(e_o[2]));
  moore_run_detector #(.RUN_LEN(1), .CNT_W(4), .EVT_W(2), .RETRIGGER(0)) d3 (
    .clock(clock), .reset(reset), .en(en), .w(w), .polarity(polarity),
    .z(z_o[3]), .z_rise(r_o[3]), .run_count(c_o[3]), .event_count(e_sat));
  moore_run_detector #(.RUN_LEN(4), .CNT_W(4), .EVT_W(8), .RETRIGGER(0)) d4 (
    .clock(clock), .reset(reset), .en(en), .w(w), .polarity(polarity),
    .z(z_o[4]), .z_rise(r_o[4]), .run_count(c_o[4]), .event_count(e_o[4]));
  moore_run_detector #(.RUN_LEN(1), .CNT_W(4), .EVT_W(8), .RETRIGGER(1)) d5 (
    .clock(clock), .reset(reset), .en(en), .w(w), .polarity(polarity),
    .z(z_o[5]), .z_rise(r_o[5]), .run_count(c_o[5]), .event_count(e_o[5]));

  assign e_o[3] = {6'b0, e_sat};

  typedef struct {
    string      tag;
    int         id;
    logic [3:0] cnt;
    logic       z;
    logic       rise;
    logic [7:0] evt;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int fails  = 0;

  task automatic check1(input string tag, input string field, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
    end
  endtask

  // Drive one sample, queue its expected outcome, then compare after the edge.
  task automatic step(input string tag, input int id, input logic rst, input logic e,
                      input logic wv, input logic p, input logic [3:0] ec,
                      input logic ez, input logic er, input logic [7:0] ee);
    exp_t x;
    reset = rst; en = e; w = wv; polarity = p;
    x.tag = tag; x.id = id; x.cnt = ec; x.z = ez; x.rise = er; x.evt = ee;
    sb.push_back(x);
    @(posedge clock);
    #1;
    x = sb.pop_front();
    check1(x.tag, "run_count",   {4'b0, c_o[x.id]}, {4'b0, x.cnt});
    check1(x.tag, "z",           {7'b0, z_o[x.id]}, {7'b0, x.z});
    check1(x.tag, "z_rise",      {7'b0, r_o[x.id]}, {7'b0, x.rise});
    check1(x.tag, "event_count", e_o[x.id],         x.evt);
  endtask

  initial begin
    @(posedge clock);
    #1;
    // Reset held two cycles with w=1, en=1
    step("rst0", 0, 1, 1, 1, 1, 0, 0, 0, 0);
    step("rst1", 0, 1, 1, 1, 1, 0, 0, 0, 0);

    // Legacy equivalence: w=1,1,1,0,1
    step("leg1", 0, 0, 1, 1, 1, 1, 0, 0, 1'b0);
    step("leg2", 0, 0, 1, 1, 1, 2, 1, 1, 1);
    step("leg3", 0, 0, 1, 1, 1, 2, 1, 0, 1);
    step("leg4", 0, 0, 1, 0, 1, 0, 0, 0, 1);
    step("leg5", 0, 0, 1, 1, 1, 1, 0, 0, 1);

    // Retrigger, RUN_LEN=3: seven ones
    step("rt_rst", 1, 1, 1, 1, 1, 0, 0, 0, 0);
    step("rt1", 1, 0, 1, 1, 1, 1, 0, 0, 0);
    step("rt2", 1, 0, 1, 1, 1, 2, 0, 0, 0);
    step("rt3", 1, 0, 1, 1, 1, 3, 1, 1, 1);
    step("rt4", 1, 0, 1, 1, 1, 1, 0, 0, 1);
    step("rt5", 1, 0, 1, 1, 1, 2, 0, 0, 1);
    step("rt6", 1, 0, 1, 1, 1, 3, 1, 1, 2);
    step("rt7", 1, 0, 1, 1, 1, 1, 0, 0, 2);

    // Enable and polarity=0, RUN_LEN=3 sticky
    step("ep_rst", 2, 1, 1, 0, 0, 0, 0, 0, 0);
    step("ep1", 2, 0, 1, 0, 0, 1, 0, 0, 0);
    step("ep2", 2, 0, 1, 0, 0, 2, 0, 0, 0);
    step("ep_dis1", 2, 0, 0, 1, 0, 2, 0, 0, 0);
    step("ep_dis2", 2, 0, 0, 1, 0, 2, 0, 0, 0);
    step("ep_dis3", 2, 0, 0, 1, 0, 2, 0, 0, 0);
    step("ep3", 2, 0, 1, 0, 0, 3, 1, 1, 1);
    step("ep4", 2, 0, 1, 0, 0, 3, 1, 0, 1);
    step("ep_dis4", 2, 0, 0, 1, 0, 3, 1, 0, 1);

    // Event counter saturation, EVT_W=2, RUN_LEN=1
    step("sat_rst", 3, 1, 1, 0, 1, 0, 0, 0, 0);
    step("sat_h1", 3, 0, 1, 1, 1, 1, 1, 1, 1);
    step("sat_l1", 3, 0, 1, 0, 1, 0, 0, 0, 1);
    step("sat_h2", 3, 0, 1, 1, 1, 1, 1, 1, 2);
    step("sat_l2", 3, 0, 1, 0, 1, 0, 0, 0, 2);
    step("sat_h3", 3, 0, 1, 1, 1, 1, 1, 1, 3);
    step("sat_l3", 3, 0, 1, 0, 1, 0, 0, 0, 3);
    step("sat_h4", 3, 0, 1, 1, 1, 1, 1, 1, 3);
    step("sat_l4", 3, 0, 1, 0, 1, 0, 0, 0, 3);
    step("sat_h5", 3, 0, 1, 1, 1, 1, 1, 1, 3);
    step("sat_hold", 3, 0, 1, 1, 1, 1, 1, 0, 3);

    // Reset mid-run, RUN_LEN=4
    step("mr_rst", 4, 1, 1, 0, 1, 0, 0, 0, 0);
    step("mr1", 4, 0, 1, 1, 1, 1, 0, 0, 0);
    step("mr2", 4, 0, 1, 1, 1, 2, 0, 0, 0);
    step("mr3", 4, 0, 1, 1, 1, 3, 0, 0, 0);
    step("mr_hit_rst", 4, 1, 1, 1, 1, 0, 0, 0, 0);
    step("mr4", 4, 0, 1, 1, 1, 1, 0, 0, 0);
    step("mr5", 4, 0, 1, 1, 1, 2, 0, 0, 0);
    step("mr6", 4, 0, 1, 1, 1, 3, 0, 0, 0);
    step("mr7", 4, 0, 1, 1, 1, 4, 1, 1, 1);
    step("mr8", 4, 0, 1, 1, 1, 4, 1, 0, 1);

    // RUN_LEN=1 retrigger: every match is a hit
    step("r1_rst", 5, 1, 1, 1, 1, 0, 0, 0, 0);
    step("r1_a", 5, 0, 1, 1, 1, 1, 1, 1, 1);
    step("r1_b", 5, 0, 1, 1, 1, 1, 1, 1, 2);
    step("r1_c", 5, 0, 1, 1, 1, 1, 1, 1, 3);
    step("r1_dis", 5, 0, 0, 1, 1, 1, 1, 0, 3);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/moore_run_detector.md
# moore_run_detector

Parametrised Moore-style run-length detector: asserts `z` once the serial input `w` has matched a programmable polarity for `RUN_LEN` consecutive enabled samples. It is the next generation of the team's two-ones sequence detector. It adds configurable run length, selectable match polarity, clock enable, a non-overlapping retrigger mode, a rising-edge pulse, and a saturating event counter. It sits on serial control/status lines as a glitch filter and event monitor. All outputs are registered.

## Interface

Parameters:
- `RUN_LEN`, default 2: number of consecutive matching samples required; must be ≥ 1.
- `CNT_W`, default 4: run counter width; requires 2^CNT_W − 1 ≥ RUN_LEN.
- `EVT_W`, default 8: event counter width.
- `RETRIGGER`, default 0: 0 = sticky mode (z holds while the run continues); 1 = non-overlapping mode (one hit per RUN_LEN matches).

Ports:
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset; priority over all other inputs.
- `en`  in  1  sample enable; when 0, the input is ignored and state holds.
- `w`  in  1  serial input sample.
- `polarity`  in  1  value of `w` counted as a match; sampled every enabled cycle.
- `z`  out  1  detect flag, equal to (run_count == RUN_LEN).
- `z_rise`  out  1  one-cycle pulse on each new hit.
- `run_count`  out  CNT_W  current consecutive-match count, 0..RUN_LEN.
- `event_count`  out  EVT_W  number of hits since reset; saturates at all-ones.

## Operation

- State is the register `cnt` (exported as `run_count`). `z` is decoded from `cnt` only (Moore). `z_rise` and `event_count` are registers.
- Reset (rising edge with `reset`=1): `cnt`=0, `z`=0, `z_rise`=0, `event_count`=0.
- `en`=0: `cnt` and `event_count` hold; `z_rise` is forced to 0.
- `en`=1 and `w` ≠ `polarity` (mismatch): `cnt` ← 0.
- `en`=1 and `w` == `polarity`, RETRIGGER=0: `cnt` ← min(cnt+1, RUN_LEN). Saturates, so `z` stays high for the rest of the run.
- `en`=1 and `w` == `polarity`, RETRIGGER=1: if `cnt`==RUN_LEN then `cnt` ← 1, else `cnt` ← cnt+1.
  - `z` is high for one cycle per RUN_LEN matches.
  - With RUN_LEN=1, `cnt` stays at 1 and `z` stays high.
- Hit definition: an enabled cycle whose next `cnt` equals RUN_LEN and where one of the following holds:
  - current `cnt` ≠ RUN_LEN; or
  - RETRIGGER=1 and RUN_LEN=1.
- On a hit, `z_rise` ← 1 and `event_count` ← event_count+1, saturating at 2^EVT_W − 1. Otherwise `z_rise` ← 0.
- A change of `polarity` mid-run takes effect on the next enabled sample. The new value is compared against `w`; `cnt` is not cleared.
- With RUN_LEN=2, RETRIGGER=0, polarity=1, en=1, behaviour is cycle-identical to the legacy detector: z=1 after two or more consecutive ones.

## Timing

- Latency: the RUN_LEN-th consecutive match is sampled at edge N. `z` and `z_rise` are high in the cycle following edge N.
- A mismatch sampled at edge M drops `z` in the cycle following edge M.
- `z_rise` is never high for two consecutive cycles, except when RUN_LEN=1 and RETRIGGER=1 with continuous matches.
- Reset mid-run: at the next rising edge, all outputs go to 0 regardless of `en`, `w` or `polarity`. Detection restarts from `cnt`=0.
- No combinational path exists from inputs to outputs.

## Test plan

- Reset: hold `reset`=1 for 2 cycles with `w`=1, `en`=1 -> `z`=0, `z_rise`=0, `run_count`=0, `event_count`=0.
- Legacy equivalence (RUN_LEN=2, RETRIGGER=0, polarity=1): `w`=1,1,1,0,1 -> `run_count`=1,2,2,0,1; `z`=0,1,1,0,0; `z_rise` high only after the 2nd sample; `event_count`=1.
- Retrigger (RUN_LEN=3, RETRIGGER=1): seven consecutive ones -> `run_count`=1,2,3,1,2,3,1; `z` and `z_rise` high after samples 3 and 6; `event_count`=2.
- Enable/polarity (RUN_LEN=3, polarity=0): `w`=0,0, then `en`=0 for 3 cycles with `w`=1, then `en`=1, `w`=0 -> count holds at 2 while disabled; `z`=1 after the third enabled zero; `z_rise`=0 throughout the disabled cycles.
- Saturation (EVT_W=2, RUN_LEN=1, RETRIGGER=0): alternate `w`=1,0 for 5 hits -> `event_count`=1,2,3,3,3.
- Reset mid-run (RUN_LEN=4): three ones, then `reset`=1 with `w`=1 -> `run_count`=0 next cycle. After release, four more ones are required before `z`=1.
